// File: rtl/ipsxe_fft_dist_fifo_ctrl.sv
// ipsxe_fft_dist_fifo_ctrl: first-word-fall-through FIFO controller for a distributed SDP RAM with registered output.
// Define IPSXE_FFT_FIFO_STATUS_EN to add the o_level / o_almost_full status outputs.
module ipsxe_fft_dist_fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
`ifdef IPSXE_FFT_FIFO_STATUS_EN
   ,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH-2
`endif
) (
   input  logic                  i_aclk,
   input  logic                  i_aresetn,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   input  logic [DATA_WIDTH-1:0] i_s_data,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_ram_wr_en,
   output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wr_data,
   output logic                  o_ram_rd_en,
   output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
`ifdef IPSXE_FFT_FIFO_STATUS_EN
   output logic [ADDR_WIDTH:0]   o_level,
   output logic                  o_almost_full,
`endif
   input  logic [DATA_WIDTH-1:0] i_ram_rd_data
);
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_ram_cnt, w_cnt_nxt;
   logic                  r_out_vld, r_run, w_wr_fire, w_fetch, w_vld_nxt;
   // r_run holds o_s_ready low until the first clock after reset release
   assign o_s_ready     = r_run & (r_ram_cnt != LP_DEPTH);
   assign w_wr_fire     = i_s_valid & o_s_ready;
   assign w_fetch       = (r_ram_cnt != '0) & (~r_out_vld | i_m_ready);
   assign w_vld_nxt     = w_fetch | (r_out_vld & ~i_m_ready);
   assign w_cnt_nxt     = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_wr_fire} - {{ADDR_WIDTH{1'b0}}, w_fetch};
   assign o_ram_wr_en   = w_wr_fire;
   assign o_ram_wr_addr = r_wr_ptr;
   assign o_ram_wr_data = i_s_data;
   assign o_ram_rd_en   = w_fetch;
   assign o_ram_rd_addr = r_rd_ptr;
   assign o_m_valid     = r_out_vld;
   assign o_m_data      = i_ram_rd_data;
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ram_cnt <= '0;
         r_out_vld <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_wr_ptr  <= w_wr_fire ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr  <= w_fetch ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_ram_cnt <= w_cnt_nxt;
         r_out_vld <= w_vld_nxt;
      end
   end
`ifdef IPSXE_FFT_FIFO_STATUS_EN
   logic [ADDR_WIDTH:0] w_lvl_nxt;
   logic                r_afull;
   assign o_level   = (r_ram_cnt == LP_DEPTH) ? r_ram_cnt : r_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_out_vld};
   assign w_lvl_nxt = (w_cnt_nxt == LP_DEPTH) ? w_cnt_nxt : w_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_vld_nxt};
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) r_afull <= 1'b0;
      else            r_afull <= (w_lvl_nxt >= (ADDR_WIDTH+1)'(AFULL_THRESH));
   end
   assign o_almost_full = r_afull;
`endif
endmodule

// File: tb/tb_ipsxe_fft_dist_fifo_ctrl.sv
// tb_ipsxe_fft_dist_fifo_ctrl: directed bench for the FWFT FIFO controller with a behavioural registered-output RAM.
module tb_ipsxe_fft_dist_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, s_valid, s_ready, m_valid, m_ready, wr_en, rd_en;
   logic [31:0] s_data, m_data, wr_data, rd_data;
   logic [3:0]  wr_addr, rd_addr;
   logic [31:0] mem [16];
   logic [31:0] exp_q [$];
   logic [31:0] hold_d;
   logic        hold_v = 1'b0;
   int          n_vec = 0, n_err = 0, n_acc = 0, n_pop = 0;

   always #5 clk = ~clk;

   ipsxe_fft_dist_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .i_aclk(clk), .i_aresetn(rst_n),
      .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
      .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
      .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr), .o_ram_wr_data(wr_data),
      .o_ram_rd_en(rd_en), .o_ram_rd_addr(rd_addr), .i_ram_rd_data(rd_data)
   );

   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sample handshakes at the falling edge, then advance to just after the next rising edge
   task automatic tick();
      @(negedge clk);
      if (hold_v) begin
         chk("stable_valid", 32'(m_valid), 32'd1);
         chk("stable_data", m_data, hold_d);
      end
      if (m_valid && m_ready) begin
         n_pop++;
         if (exp_q.size() == 0) chk("unexpected_pop", 32'(m_valid), 32'd0);
         else chk("order", m_data, exp_q.pop_front());
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (s_valid && s_ready) begin
         n_acc++;
         exp_q.push_back(s_data);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      s_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel_s_ready_before_clk", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_s_ready", 32'(s_ready), 32'd1);
      // single word latency into an empty FIFO
      s_valid = 1'b1; s_data = 32'h11; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("lat_valid_c1", 32'(m_valid), 32'd0);
      chk("lat_fetch_c1", 32'(rd_en), 32'd1);
      tick();
      chk("lat_valid_c2", 32'(m_valid), 32'd1);
      chk("lat_data_c2", m_data, 32'h11);
      tick();
      chk("lat_drained", 32'(m_valid), 32'd0);
      // fill with the sink stalled
      n_acc = 0; n_pop = 0; m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1; s_data = 32'(i);
         tick();
      end
      chk("full_accepted", 32'(n_acc), 32'd17);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_m_valid", 32'(m_valid), 32'd1);
      chk("full_head", m_data, 32'd0);
      s_valid = 1'b0; m_ready = 1'b1;
      #1;
      chk("full_pop_s_ready", 32'(s_ready), 32'd0);
      chk("full_pop_fetch", 32'(rd_en), 32'd1);
      tick();
      chk("full_freed_s_ready", 32'(s_ready), 32'd1);
      repeat (20) tick();
      chk("full_drain_pops", 32'(n_pop), 32'd17);
      chk("full_drain_empty", 32'(exp_q.size()), 32'd0);
      // continuous streaming across six pointer wraps
      n_acc = 0; n_pop = 0;
      for (int n = 0; n < 100; n++) begin
         s_valid = 1'b1; s_data = 32'h1000 + 32'(n);
         tick();
      end
      chk("stream_pops_in_loop", 32'(n_pop), 32'd98);
      s_valid = 1'b0;
      repeat (4) tick();
      chk("stream_accepted", 32'(n_acc), 32'd100);
      chk("stream_pops", 32'(n_pop), 32'd100);
      chk("stream_empty", 32'(exp_q.size()), 32'd0);
      // random valid/ready traffic
      n_acc = 0; n_pop = 0;
      for (int c = 0; c < 6000 && n_acc < 1000; c++) begin
         s_valid = (n_acc < 1000) && ($urandom_range(0, 1) == 1);
         s_data  = $urandom;
         m_ready = ($urandom_range(0, 1) == 1);
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (40) tick();
      chk("rand_accepted", 32'(n_acc), 32'd1000);
      chk("rand_pops", 32'(n_pop), 32'd1000);
      chk("rand_empty", 32'(exp_q.size()), 32'd0);
      // asynchronous reset with seven words stored
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_data = 32'h700 + 32'(i);
         tick();
      end
      s_valid = 1'b0;
      chk("pre_rst_valid", 32'(m_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(m_valid), 32'd0);
      chk("async_rst_s_ready", 32'(s_ready), 32'd0);
      exp_q.delete();
      hold_v = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_acc = 0; n_pop = 0;
      s_valid = 1'b1; s_data = 32'hAB; m_ready = 1'b1;
      for (int c = 0; c < 5 && n_acc == 0; c++) tick();
      s_valid = 1'b0;
      repeat (8) tick();
      chk("post_rst_accepted", 32'(n_acc), 32'd1);
      chk("post_rst_pops", 32'(n_pop), 32'd1);
      chk("post_rst_empty", 32'(exp_q.size()), 32'd0);
      chk("post_rst_valid", 32'(m_valid), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
